// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the programmable FIFO.
//   rd_mode_e : read-port style. FWFT shows the head word combinationally;
//               REG_OUT registers the word one cycle after the read is accepted.
//   is_pow2   : constant function for the elaboration-time parameter checks.
package fifo_pkg;

    typedef enum logic {
        FWFT    = 1'b0,
        REG_OUT = 1'b1
    } rd_mode_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: storage array for fifo_prog.
// Synchronous write, asynchronous read. Contents are never reset.
//   clk    : write clock (rising edge)
//   we     : write enable
//   waddr  : write address
//   wdata  : write word
//   raddr  : read address
//   rdata  : word at raddr (combinational)
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog: single-clock FIFO with selectable read style, programmable
// almost-full / almost-empty thresholds and sticky overflow/underflow flags.
//   clk, rst          : clock and synchronous active-high reset
//   wr_en, wr_data    : write request and word
//   rd_en             : read request (acknowledges the shown word in FWFT)
//   rd_data, rd_valid : read word and its qualifier
//   full, empty, almost_full, almost_empty : flags decoded from count
//   count             : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags, cleared by err_clr
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int       DATA_WIDTH = 8,
    parameter int       DEPTH      = 16,
    parameter rd_mode_e RD_MODE    = FWFT,
    parameter int       AF_THRESH  = DEPTH - 2,
    parameter int       AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("fifo_prog: DEPTH must be a power of 2 and at least 4");
    end
    if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("fifo_prog: thresholds must satisfy 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] ram_q;

    assign full         = (count == FULL_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Memory write is gated by rst so nothing lands during a reset cycle.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wptr),
        .wdata (wr_data),
        .raddr (rptr),
        .rdata (ram_q)
    );

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // DEPTH is a power of 2, so the pointers wrap naturally.
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;

            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end

            // A new error event takes priority over a simultaneous clear.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    if (RD_MODE == REG_OUT) begin : g_reg_out
        logic [DATA_WIDTH-1:0] data_q;
        logic                  vld_q;

        // Read register: one-cycle latency from accepted read to rd_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= ram_q;
                end
            end
        end

        assign rd_data  = data_q;
        assign rd_valid = vld_q;
    end else begin : g_fwft
        assign rd_data  = ram_q;
        assign rd_valid = !empty;
    end

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: directed bench for fifo_prog (DATA_WIDTH=8, DEPTH=16, AF=14, AE=2).
// Two instances share the stimulus: one FWFT, one REG_OUT.
module tb_fifo_prog;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] f_rd_data, r_rd_data;
    logic       f_rd_valid, r_rd_valid;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic       r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [4:0] f_count, r_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_prog #(
        .DATA_WIDTH (8), .DEPTH (16), .RD_MODE (FWFT), .AF_THRESH (14), .AE_THRESH (2)
    ) u_fwft (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
        .rd_data (f_rd_data), .rd_valid (f_rd_valid), .full (f_full), .empty (f_empty),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_unf), .err_clr (err_clr)
    );

    fifo_prog #(
        .DATA_WIDTH (8), .DEPTH (16), .RD_MODE (REG_OUT), .AF_THRESH (14), .AE_THRESH (2)
    ) u_reg (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
        .rd_data (r_rd_data), .rd_valid (r_rd_valid), .full (r_full), .empty (r_empty),
        .almost_full (r_af), .almost_empty (r_ae), .count (r_count),
        .overflow (r_ovf), .underflow (r_unf), .err_clr (err_clr)
    );

    typedef struct {
        string      name;
        logic       rst, wr, rd, clr;
        logic [7:0] wd;
        int         cnt;
        logic       full, empty, af, ae, ovf, unf, vld;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string name, logic r, logic w, logic [7:0] wd, logic rd,
                                logic clr, int cnt, logic fu, logic em, logic af,
                                logic ae, logic ovf, logic unf, logic vld,
                                logic [7:0] dout);
        vec_t v;
        v.name = name; v.rst = r; v.wr = w; v.wd = wd; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.full = fu; v.empty = em; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.vld = vld; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic w, input logic [7:0] wd,
                        input logic rd, input logic clr);
        rst = r; wr_en = w; wr_data = wd; rd_en = rd; err_clr = clr;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        int         k;
        logic [7:0] w;

        // ---------------- table: fill / full / err_clr / reset / underflow
        vt.push_back(mk("reset", 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        for (int i = 1; i <= 16; i++) begin
            vt.push_back(mk("wr_ramp", 0, 1, 8'(i), 0, 0, i, (i == 16), 0, (i >= 14),
                            (i <= 2), 0, 0, 1, 8'h01));
        end
        vt.push_back(mk("wr_when_full", 0, 1, 8'h11, 0, 0, 16, 1, 0, 1, 0, 1, 0, 1, 8'h01));
        vt.push_back(mk("clr_vs_ovf",   0, 1, 8'h22, 0, 1, 16, 1, 0, 1, 0, 1, 0, 1, 8'h01));
        vt.push_back(mk("clr_alone",    0, 0, 8'h00, 0, 1, 16, 1, 0, 1, 0, 0, 0, 1, 8'h01));
        vt.push_back(mk("full_wr_rd",   0, 1, 8'h33, 1, 0, 16, 1, 0, 1, 0, 0, 0, 1, 8'h02));
        for (int i = 1; i <= 7; i++) begin
            vt.push_back(mk("drain", 0, 0, 8'h00, 1, 0, 16 - i, 0, 0, (16 - i >= 14), 0,
                            0, 0, 1, 8'(8'h02 + i)));
        end
        vt.push_back(mk("rst_mid",      1, 1, 8'hAA, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        vt.push_back(mk("idle_post_rst",0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        vt.push_back(mk("wr_rd_empty",  0, 1, 8'h44, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 8'h44));
        vt.push_back(mk("rd_last",      0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00));
        vt.push_back(mk("clr_unf",      0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        vt.push_back(mk("rd_empty",     0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00));
        vt.push_back(mk("clr_both",     0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));

        @(negedge clk);
        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].wr, vt[i].wd, vt[i].rd, vt[i].clr);
            chk({vt[i].name, ".count"}, int'(f_count), vt[i].cnt);
            chk({vt[i].name, ".full"},  int'(f_full),  int'(vt[i].full));
            chk({vt[i].name, ".empty"}, int'(f_empty), int'(vt[i].empty));
            chk({vt[i].name, ".af"},    int'(f_af),    int'(vt[i].af));
            chk({vt[i].name, ".ae"},    int'(f_ae),    int'(vt[i].ae));
            chk({vt[i].name, ".ovf"},   int'(f_ovf),   int'(vt[i].ovf));
            chk({vt[i].name, ".unf"},   int'(f_unf),   int'(vt[i].unf));
            chk({vt[i].name, ".vld"},   int'(f_rd_valid), int'(vt[i].vld));
            if (vt[i].vld) chk({vt[i].name, ".dout"}, int'(f_rd_data), int'(vt[i].dout));
            if (vt[i].rst) chk({vt[i].name, ".reg_vld"}, int'(r_rd_valid), 0);
        end

        // ---------------- REG_OUT: three writes, three back-to-back reads
        step(1, 0, 8'h00, 0, 0);
        chk("reg_rst_data", int'(r_rd_data), 0);
        step(0, 1, 8'hA1, 0, 0);
        step(0, 1, 8'hA2, 0, 0);
        step(0, 1, 8'hA3, 0, 0);
        chk("reg_vld_before_rd", int'(r_rd_valid), 0);
        chk("reg_count3", int'(r_count), 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00, 1, 0);
            chk("reg_rd_vld", int'(r_rd_valid), 1);
            chk("reg_rd_data", int'(r_rd_data), int'(8'hA1 + 8'(i)));
        end
        step(0, 0, 8'h00, 0, 0);
        chk("reg_vld_drop", int'(r_rd_valid), 0);
        chk("reg_data_hold", int'(r_rd_data), int'(8'hA3));
        chk("reg_unf_clear", int'(r_unf), 0);
        step(0, 0, 8'h00, 1, 0);
        chk("reg_rd_empty_unf", int'(r_unf), 1);
        chk("reg_rd_empty_vld", int'(r_rd_valid), 0);
        chk("reg_rd_empty_hold", int'(r_rd_data), int'(8'hA3));

        // ---------------- wrap-around: 40 write/read pairs
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 40; i++) begin
            w = 8'(8'h50 + i * 3);
            step(0, 1, w, 0, 0);
            chk("wrap_cnt_wr", int'(f_count), 1);
            chk("wrap_head", int'(f_rd_data), int'(w));
            step(0, 0, 8'h00, 1, 0);
            chk("wrap_cnt_rd", int'(f_count), 0);
            chk("wrap_reg_data", int'(r_rd_data), int'(w));
        end
        chk("wrap_no_unf", int'(f_unf), 0);
        chk("wrap_no_ovf", int'(f_ovf), 0);

        // ---------------- reset with count=9: stale data must not come back
        for (int i = 0; i < 9; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
        chk("pre_rst_count9", int'(f_count), 9);
        step(1, 0, 8'h00, 0, 0);
        chk("rst9_count", int'(f_count), 0);
        chk("rst9_empty", int'(f_empty), 1);
        chk("rst9_vld", int'(f_rd_valid), 0);
        chk("rst9_reg_vld", int'(r_rd_valid), 0);
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 1, 0);
            if (f_rd_valid || r_rd_valid) k++;
        end
        chk("rst9_no_reappear", k, 0);
        step(0, 1, 8'h7E, 0, 0);
        chk("rst9_new_head", int'(f_rd_data), int'(8'h7E));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the entry count; power of 2, minimum 4.
REQ-003 SHALL have parameter RD_MODE, default FWFT, meaning the read mode (fifo_pkg::rd_mode_e): FWFT or REG_OUT.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, meaning almost_full asserts when count >= AF_THRESH.
REQ-005 SHALL have parameter AE_THRESH, default 2, meaning almost_empty asserts when count <= AE_THRESH.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset; one clock; reset is synchronous and active-high.
REQ-008 SHALL have ports wr_en (input, 1) and wr_data (input, DATA_WIDTH): write request and write word.
REQ-009 SHALL have port rd_en, input, 1 bit: read request.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH: read word.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data is qualified.
REQ-012 SHALL have ports full, empty, almost_full and almost_empty: outputs, 1 bit each, status flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: occupancy, 0..DEPTH.
REQ-014 SHALL have ports overflow and underflow: outputs, 1 bit each, sticky error flags.
REQ-015 SHALL have port err_clr, input, 1 bit: clears overflow and underflow.

Function
REQ-016 SHALL compute rd_acc = rd_en && !empty.
REQ-017 SHALL compute wr_acc = wr_en && (!full || rd_acc), so that a write is accepted when full if a read is accepted in the same cycle.
REQ-018 SHALL, on wr_acc, store wr_data at wptr; wptr SHALL wrap from DEPTH-1 to 0.
REQ-019 SHALL, on rd_acc, advance rptr; rptr SHALL wrap from DEPTH-1 to 0.
REQ-020 SHALL update count as follows: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
REQ-021 SHALL derive the flags from registered count: full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH).
REQ-022 SHALL, in FWFT mode, drive rd_data = mem[rptr] combinationally and rd_valid = !empty; rd_en acknowledges the displayed word.
REQ-023 SHALL, in REG_OUT mode, register rd_data <= mem[rptr] on rd_acc and drive rd_valid high for exactly the following cycle; otherwise rd_data holds its value and rd_valid is 0.
REQ-024 SHALL set overflow to 1 on wr_en && !wr_acc, and set underflow to 1 on rd_en && empty.
REQ-025 SHALL hold overflow and underflow until err_clr; if a set event and err_clr occur in the same cycle, the set event SHALL win.
REQ-026 SHALL ignore rejected writes and reads entirely: no pointer, count or memory change.
REQ-027 SHALL, on a simultaneous write and read when empty, make the write take effect while the read is rejected (underflow sets); count goes to 1.
REQ-028 SHALL, in REG_OUT mode, keep read latency at 1 cycle from rd_acc to rd_valid.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, clear wptr, rptr, count, overflow, underflow, rd_valid and REG_OUT rd_data to 0.
REQ-030 SHALL, after reset, present empty=1, almost_empty=1, full=0 and almost_full=0 (unless AF_THRESH==0).
REQ-031 SHALL NOT reset memory contents.
REQ-032 SHALL, on reset mid-operation, discard all stored data and reject any rd_en/wr_en in the reset cycle.

Structure
REQ-033 SHALL place typedef enum rd_mode_e {FWFT, REG_OUT} in package fifo_pkg.
REQ-034 SHALL perform elaboration-time checks in fifo_pkg or fifo_prog: DEPTH a power of 2 and ≥ 4; 0 < AE_THRESH < AF_THRESH ≤ DEPTH.
REQ-035 SHALL implement storage as one sub-module, fifo_ram, with parameters DATA_WIDTH and DEPTH, synchronous write and asynchronous read; fifo_prog holds pointers, count, flags and the read register.

Verification (DATA_WIDTH=8, DEPTH=16, AF=14, AE=2)
REQ-036 SHALL verify: write 0x01..0x10 with no reads -> count=16, full=1, almost_full from count=14; 17th write sets overflow and count stays 16.
REQ-037 SHALL verify: from full, wr_en+rd_en for 1 cycle -> 0x01 read, new word accepted, count stays 16, overflow stays 0.
REQ-038 SHALL verify: REG_OUT, 3 words then 3 back-to-back reads -> rd_valid high on cycles +1..+3 with data in write order; rd_en when empty sets underflow.
REQ-039 SHALL verify: wrap-around -> 40 interleaved write/read pairs keep order across pointer wrap, count never exceeds 1.
REQ-040 SHALL verify: rst asserted with count=9 -> next cycle count=0, empty=1, rd_valid=0, and old data never reappears.
REQ-041 SHALL verify: err_clr with a simultaneous overflow event -> overflow stays 1; err_clr alone -> overflow and underflow go to 0.
